// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display.
// Issues one nibble per clk_1k edge and drives the digit select one edge later.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIG    = 6,
    parameter int unsigned BLINK_HALF = 250
) (
    input  logic                   clk_1k,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [4*NUM_DIG-1:0]   disp_data,
    input  logic                   disp_load,
    input  logic                   lz_blank,
    input  logic [NUM_DIG-1:0]     blink_mask,
    output logic [3:0]             seg_data,
    output logic [NUM_DIG-1:0]     sel,
    output logic                   frame_start
);

    localparam int unsigned PW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_DIG - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

    logic [PW-1:0]          ptr_q, ptr_d;
    logic [4*NUM_DIG-1:0]   active_q, active_d;
    logic [4*NUM_DIG-1:0]   pending_q, pending_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [CW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_ph_q, blink_ph_d;
    logic [3:0]             seg_q, seg_d;
    logic [PW-1:0]          slot_q, slot_d;
    logic                   blank_q, blank_d;
    logic                   fs_q, fs_d;
    logic [NUM_DIG-1:0]     sel_q, sel_d;

    logic [3:0]             nib [NUM_DIG];
    logic [NUM_DIG-1:0]     blank_vec;
    logic                   wrap;
    logic                   cnt_last;
    logic [3:0]             cur_nib;
    logic                   cur_blank;
    logic                   zero_up;

    assign wrap     = en && (ptr_q == PTR_LAST);
    assign cnt_last = (blink_cnt_q == CNT_LAST);

    // Per-digit blanking: leading-zero run from the top digit down, plus blink.
    always_comb begin
        blank_vec = '0;
        zero_up   = 1'b0;
        for (int i = 0; i < NUM_DIG; i++) begin
            nib[i] = active_q[4*i +: 4];
        end
        for (int i = 0; i < NUM_DIG; i++) begin
            zero_up = 1'b1;
            for (int j = 0; j < NUM_DIG; j++) begin
                if (j >= i && nib[j] != 4'h0) begin
                    zero_up = 1'b0;
                end
            end
            blank_vec[i] = (lz_blank && (i != 0) && zero_up)
                         || (blink_ph_q && blink_mask[i]);
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (ptr_q == PW'(i)) begin
                cur_nib   = nib[i];
                cur_blank = blank_vec[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    // Active only moves at the frame wrap so a frame never mixes two values.
    always_comb begin
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        if (disp_load) begin
            pending_d  = disp_data;
            pend_vld_d = 1'b1;
        end
        if (wrap) begin
            pend_vld_d = 1'b0;
            if (disp_load) begin
                active_d = disp_data;
            end else if (pend_vld_q) begin
                active_d = pending_q;
            end
        end
    end

    always_comb begin
        blink_cnt_d = cnt_last ? '0 : blink_cnt_q + CW'(1);
        blink_ph_d  = blink_ph_q ^ cnt_last;
    end

    always_comb begin
        seg_d   = cur_nib;
        slot_d  = ptr_q;
        blank_d = cur_blank || !en;
        fs_d    = en && (ptr_q == '0);
    end

    // Select trails the nibble by one edge to match the encoder register.
    always_comb begin
        sel_d = '1;
        if (!blank_q) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                if (slot_q == PW'(i)) begin
                    sel_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_vld_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= 4'h0;
            slot_q      <= '0;
            blank_q     <= 1'b1;
            fs_q        <= 1'b0;
            sel_q       <= '1;
        end else begin
            ptr_q       <= ptr_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_vld_q  <= pend_vld_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            slot_q      <= slot_d;
            blank_q     <= blank_d;
            fs_q        <= fs_d;
            sel_q       <= sel_d;
        end
    end

    assign seg_data    = seg_q;
    assign sel         = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: scan order, shadow loads, blanking,
// blink, enable gating and reset, sampled on the falling edge.
module tb_seg_scan_ctrl;

    localparam int NUM_DIG = 6;
    localparam int BH      = 4;

    logic        clk_1k = 1'b0;
    logic        rst_n  = 1'b1;
    logic        en = 1'b0;
    logic [23:0] disp_data = '0;
    logic        disp_load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [5:0]  blink_mask = '0;
    logic [3:0]  seg_data;
    logic [5:0]  sel;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    // bench-side pointer and blink phase, advanced once per clock
    int mptr = 0;
    int mcnt = 0;
    logic mph = 1'b0;
    int edge_ptr = 0;
    logic edge_ph = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIG    (NUM_DIG),
        .BLINK_HALF (BH)
    ) dut (
        .clk_1k      (clk_1k),
        .rst_n       (rst_n),
        .en          (en),
        .disp_data   (disp_data),
        .disp_load   (disp_load),
        .lz_blank    (lz_blank),
        .blink_mask  (blink_mask),
        .seg_data    (seg_data),
        .sel         (sel),
        .frame_start (frame_start)
    );

    always #5 clk_1k = ~clk_1k;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [3:0] nibble(input logic [23:0] v, input int k);
        return 4'(v >> (4 * k));
    endfunction

    function automatic logic [5:0] sel_of(input int d);
        logic [5:0] one;
        one = 6'b000001;
        return ~(one << d);
    endfunction

    task automatic tick();
        @(negedge clk_1k);
        if (!rst_n) begin
            mptr = 0;
            mcnt = 0;
            mph  = 1'b0;
        end else begin
            edge_ptr = mptr;
            edge_ph  = mph;
            if (en) mptr = (mptr == NUM_DIG - 1) ? 0 : mptr + 1;
            if (mcnt == BH - 1) begin
                mcnt = 0;
                mph  = ~mph;
            end else begin
                mcnt = mcnt + 1;
            end
        end
    endtask

    task automatic goto_ptr(input int p);
        for (int n = 0; n < NUM_DIG && mptr != p; n++) tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (sel !== 6'h3F) begin
                errors++;
                $display("FAIL reset_sel k=%0d got %b want 111111", k, sel);
            end
            checks++;
            if (seg_data !== 4'h0) begin
                errors++;
                $display("FAIL reset_seg k=%0d got %h want 0", k, seg_data);
            end
            checks++;
            if (frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_fs k=%0d got %b want 0", k, frame_start);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [23:0] v;
        v = 24'h123456;
        en = 1'b1;
        lz_blank = 1'b0;
        blink_mask = '0;
        disp_data = v;
        disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        goto_ptr(0);
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 6) begin
                checks++;
                if (seg_data !== nibble(v, k)) begin
                    errors++;
                    $display("FAIL scan_seg k=%0d got %h want %h",
                             k, seg_data, nibble(v, k));
                end
                checks++;
                if (frame_start !== (k == 0)) begin
                    errors++;
                    $display("FAIL scan_fs k=%0d got %b want %b",
                             k, frame_start, (k == 0));
                end
            end
            if (k > 0) begin
                checks++;
                if (sel !== sel_of(k - 1)) begin
                    errors++;
                    $display("FAIL scan_sel k=%0d got %b want %b",
                             k, sel, sel_of(k - 1));
                end
            end
        end
    endtask

    task automatic test_midframe_load();
        logic [23:0] old_v;
        logic [23:0] new_v;
        old_v = 24'h123456;
        new_v = 24'hABCDEF;
        goto_ptr(0);
        for (int k = 0; k < 6; k++) begin
            disp_load = (k == 2);
            disp_data = new_v;
            tick();
            checks++;
            if (seg_data !== nibble(old_v, k)) begin
                errors++;
                $display("FAIL midload_old k=%0d got %h want %h",
                         k, seg_data, nibble(old_v, k));
            end
        end
        disp_load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (seg_data !== nibble(new_v, k)) begin
                errors++;
                $display("FAIL midload_new k=%0d got %h want %h",
                         k, seg_data, nibble(new_v, k));
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [23:0] v;
        logic [5:0]  exp;
        v = 24'h000042;
        goto_ptr(0);
        lz_blank = 1'b1;
        disp_data = v;
        disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        goto_ptr(0);
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 6) begin
                checks++;
                if (seg_data !== nibble(v, k)) begin
                    errors++;
                    $display("FAIL lz42_seg k=%0d got %h want %h",
                             k, seg_data, nibble(v, k));
                end
            end
            if (k > 0) begin
                exp = (k - 1 < 2) ? sel_of(k - 1) : 6'h3F;
                checks++;
                if (sel !== exp) begin
                    errors++;
                    $display("FAIL lz42_sel k=%0d got %b want %b", k, sel, exp);
                end
            end
        end
        goto_ptr(0);
        disp_data = 24'h000000;
        disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        goto_ptr(0);
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 6) begin
                checks++;
                if (seg_data !== 4'h0) begin
                    errors++;
                    $display("FAIL lz0_seg k=%0d got %h want 0", k, seg_data);
                end
            end
            if (k > 0) begin
                exp = (k == 1) ? 6'b111110 : 6'h3F;
                checks++;
                if (sel !== exp) begin
                    errors++;
                    $display("FAIL lz0_sel k=%0d got %b want %b", k, sel, exp);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [5:0] exp;
        int   pp;
        logic pph;
        lz_blank = 1'b0;
        blink_mask = 6'b000001;
        goto_ptr(0);
        disp_data = 24'h123456;
        disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        goto_ptr(0);
        pp  = 0;
        pph = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (k > 0) begin
                exp = (pp == 0 && pph) ? 6'h3F : sel_of(pp);
                checks++;
                if (sel !== exp) begin
                    errors++;
                    $display("FAIL blink_sel k=%0d got %b want %b", k, sel, exp);
                end
            end
            pp  = edge_ptr;
            pph = edge_ph;
        end
        blink_mask = '0;
    endtask

    task automatic test_enable_wrap_load();
        logic [23:0] held;
        logic [23:0] wrap_v;
        held   = 24'h654321;
        wrap_v = 24'h789ABC;
        blink_mask = '0;
        goto_ptr(3);
        en = 1'b0;
        disp_data = held;
        disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        checks++;
        if (sel !== 6'b111011) begin
            errors++;
            $display("FAIL en_off_sel1 got %b want 111011", sel);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (sel !== 6'h3F) begin
                errors++;
                $display("FAIL en_off_sel k=%0d got %b want 111111", k, sel);
            end
            checks++;
            if (seg_data !== 4'h3 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL en_off_hold k=%0d got %h/%b want 3/0",
                         k, seg_data, frame_start);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (seg_data !== 4'h3 || sel !== 6'h3F) begin
            errors++;
            $display("FAIL en_resume1 got %h/%b want 3/111111", seg_data, sel);
        end
        tick();
        checks++;
        if (seg_data !== 4'h2 || sel !== 6'b110111) begin
            errors++;
            $display("FAIL en_resume2 got %h/%b want 2/110111", seg_data, sel);
        end
        goto_ptr(0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (seg_data !== nibble(held, k)) begin
                errors++;
                $display("FAIL en_pending k=%0d got %h want %h",
                         k, seg_data, nibble(held, k));
            end
        end
        disp_data = 24'h2468AC;
        disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        goto_ptr(NUM_DIG - 1);
        disp_data = wrap_v;
        disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (seg_data !== nibble(wrap_v, k % 6)) begin
                errors++;
                $display("FAIL wrap_load k=%0d got %h want %h",
                         k, seg_data, nibble(wrap_v, k % 6));
            end
        end
    endtask

    task automatic test_reset_midframe();
        goto_ptr(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 6'h3F || seg_data !== 4'h0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got %b/%h/%b want 111111/0/0",
                     sel, seg_data, frame_start);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 6) begin
                checks++;
                if (seg_data !== 4'h0 || frame_start !== (k == 0)) begin
                    errors++;
                    $display("FAIL rst_lost k=%0d got %h/%b want 0/%b",
                             k, seg_data, frame_start, (k == 0));
                end
            end
            if (k > 0) begin
                checks++;
                if (sel !== sel_of(k - 1)) begin
                    errors++;
                    $display("FAIL rst_sel k=%0d got %b want %b",
                             k, sel, sel_of(k - 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_lz_blank();
        test_blink();
        test_enable_wrap_load();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
